seq_alu_exec: RTL and testbench
===============================

SEQ_ALU_EXEC -- requirements
Module: seq_alu_exec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (legal range 16..64).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port start_i  input  1  request to begin one operation.
REQ-005 SHALL have port ALU_Operation_i  input  4  operation code from the ALU control decoder.
REQ-006 SHALL have port A_i  input  DATA_WIDTH  operand A (rs1).
REQ-007 SHALL have port B_i  input  DATA_WIDTH  operand B (rs2 or immediate).
REQ-008 SHALL have port busy_o  output  1  high while a multi-cycle shift is in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port ALU_Result_o  output  DATA_WIDTH  registered result.
REQ-011 SHALL have port Zero_o  output  1  high when ALU_Result_o equals zero.
REQ-012 Reset SHALL be synchronous and active-high on port reset, sampled on the rising edge of clk, the only clock.

Function
REQ-013 Operation codes SHALL be: 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 LUI {B[19:0],12'b0} zero-extended; 0110 SRL logical right; 0111 SLL left.
REQ-014 Codes 1000-1111 SHALL produce result 0 with single-cycle latency.
REQ-015 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no carry or overflow output.
REQ-016 Shift amount SHALL be B_i[log2(DATA_WIDTH)-1:0]; upper bits of B_i ignored.
REQ-017 A request SHALL be accepted on a rising edge where start_i=1 and busy_o=0; A_i, B_i, ALU_Operation_i captured at that edge only.
REQ-018 start_i while busy_o=1 SHALL be ignored with no effect on state, result or timing.
REQ-019 State machine SHALL have states IDLE, SHIFT, DONE.
REQ-020 IDLE/DONE + accept: non-shift code or shamt 0 -> DONE with result loaded; shift with shamt n>0 -> SHIFT, result register loaded with A, counter loaded with n.
REQ-021 SHIFT SHALL shift result register one bit per cycle in requested direction, zero fill, decrement counter; last bit shifted -> DONE.
REQ-022 DONE SHALL last exactly one cycle then return to IDLE unless a new request is accepted in that cycle (back-to-back allowed).
REQ-023 Latency SHALL be 1 cycle for non-shift ops, 1+n cycles for shifts of n; done_o high in the cycle at that latency after the accepting edge.
REQ-024 busy_o SHALL equal 1 exactly while in SHIFT; done_o exactly while in DONE.
REQ-025 ALU_Result_o and Zero_o SHALL hold final values from DONE until the next accepted request completes; intermediate shift values not guaranteed.
REQ-026 Zero_o SHALL be registered and consistent with ALU_Result_o in every cycle.

Reset
REQ-027 While reset=1 at an edge: state IDLE, counter 0, ALU_Result_o 0, Zero_o 1, busy_o 0, done_o 0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done_o pulse.
REQ-029 start_i sampled together with reset=1 SHALL be ignored.

Configuration
REQ-030 Macro SEQ_ALU_FAST_SHIFT_EN defined: SRL/SLL SHALL use a single-cycle barrel shifter, latency 1, SHIFT state never entered, busy_o constant 0.
REQ-031 Macro undefined: iterative shifting per REQ-020..REQ-023 SHALL apply; all other behaviour identical in both builds.

Verification
REQ-032 ADD A=5 B=7 start pulse -> next cycle done_o=1, ALU_Result_o=12, Zero_o=0, busy_o=0.
REQ-033 SUB A=3 B=3 -> result 0, Zero_o=1; SUB A=0 B=1 -> result 0xFFFFFFFF.
REQ-034 SLL A=1 B=31 -> busy_o high 31 cycles, done_o on cycle 32, result 0x80000000; with SEQ_ALU_FAST_SHIFT_EN done_o on cycle 1.
REQ-035 SRL A=0xF0000000 B=0x24 (shamt 4) -> result 0x0F000000 at cycle 5; start_i held high with new ops during busy -> ignored; op issued in DONE cycle accepted back-to-back.
REQ-036 SLL shamt 10 then reset at cycle 4 -> next cycle busy_o=0, done_o never pulses, ALU_Result_o=0, Zero_o=1; code 1010 afterwards -> result 0 at cycle 1.

Source files
------------

// File: rtl/seq_alu_exec.sv
// rtl/seq_alu_exec.sv - sequential ALU with iterative (or optional barrel) shifter
//
// Purpose: executes one ALU operation per accepted request. ADD/SUB/AND/OR/XOR/LUI
//          and the reserved codes finish one cycle after the accepting edge. SRL/SLL
//          shift one bit per cycle, so a shift of n finishes 1+n cycles after accept.
//
// Configuration macro: SEQ_ALU_FAST_SHIFT_EN
//          defined   - SRL/SLL use a single-cycle barrel shifter; SHIFT is never entered.
//          undefined - iterative shifting (default build).
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous active-high reset
//   start_i          in   request; accepted when busy_o is low
//   ALU_Operation_i  in   [3:0] operation code
//   A_i, B_i         in   [DATA_WIDTH-1:0] operands (B_i low bits give shift amount)
//   busy_o           out  high while an iterative shift is in progress
//   done_o           out  one-cycle pulse, result valid
//   ALU_Result_o     out  [DATA_WIDTH-1:0] registered result
//   Zero_o           out  registered, high when ALU_Result_o is zero

module seq_alu_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [SHW-1:0]        count;
    logic                  dir_left;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  busy;
    logic                  done;

    logic [SHW-1:0]        shamt;
    logic                  is_shift;
    logic                  go_iter;
    logic [19:0]           b_low20;
    logic [DATA_WIDTH-1:0] lui_val;
    logic [DATA_WIDTH-1:0] op_result;
    logic [DATA_WIDTH-1:0] stepped;

    assign shamt    = B_i[SHW-1:0];
    assign is_shift = (ALU_Operation_i[3:1] == 3'b011);

    // Cast handles widths below 20 bits (zero-extend) as well as wider ones.
    assign b_low20  = 20'(B_i);
    assign lui_val  = DATA_WIDTH'({b_low20, 12'b0});

`ifdef SEQ_ALU_FAST_SHIFT_EN
    assign go_iter = 1'b0;
`else
    assign go_iter = is_shift && (shamt != '0);
`endif

    always_comb begin
        op_result = '0;
        case (ALU_Operation_i)
            4'b0000: op_result = A_i + B_i;
            4'b0001: op_result = A_i - B_i;
            4'b0010: op_result = A_i & B_i;
            4'b0011: op_result = A_i | B_i;
            4'b0100: op_result = A_i ^ B_i;
            4'b0101: op_result = lui_val;
`ifdef SEQ_ALU_FAST_SHIFT_EN
            4'b0110: op_result = A_i >> shamt;
            4'b0111: op_result = A_i << shamt;
`else
            // Only reached directly when the shift amount is zero.
            4'b0110,
            4'b0111: op_result = A_i;
`endif
            default: op_result = '0;
        endcase
    end

    assign stepped = dir_left ? (result << 1) : (result >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            dir_left <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    // start_i is deliberately not looked at here.
                    result <= stepped;
                    zero   <= (stepped == '0);
                    count  <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        if (go_iter) begin
                            state    <= ST_SHIFT;
                            result   <= A_i;
                            zero     <= (A_i == '0);
                            count    <= shamt;
                            dir_left <= ALU_Operation_i[0];
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state  <= ST_DONE;
                            result <= op_result;
                            zero   <= (op_result == '0);
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign ALU_Result_o = result;
    assign Zero_o       = zero;

endmodule

// File: tb/tb_seq_alu_exec.sv
// tb/tb_seq_alu_exec.sv - self-checking bench for seq_alu_exec (default build)

module tb_seq_alu_exec;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res = 32'h0;

    seq_alu_exec #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: result of an operation from the opcode table.
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return b[19:0] * 32'd4096;
            4'd6: return a >> sh;
            4'd7: return a << sh;
            default: return 32'h0;
        endcase
    endfunction

    // Reference: cycles from the accepting edge to done_o.
    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd6 || op == 4'd7) && (b % 32) != 0)
            return 1 + int'(b % 32);
        return 1;
    endfunction

    task automatic scramble_inputs();
        ALU_Operation_i = 4'($urandom);
        A_i = $urandom;
        B_i = $urandom;
    endtask

    // Called 1 time unit after a rising edge with the DUT able to accept.
    // Returns in the done cycle with start_i low, so a following call is back-to-back.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hammer);
        logic [31:0] exp;
        int lat;
        int cyc;
        exp = model_res(op, a, b);
        lat = model_lat(op, b);
        start_i = 1'b1;
        ALU_Operation_i = op;
        A_i = a;
        B_i = b;
        @(posedge clk); #1;
        cyc = 1;
        start_i = hammer;
        if (hammer) scramble_inputs();
        while (!done_o && cyc < 100) begin
            check("busy_during_shift", 32'(busy_o), 32'd1);
            @(posedge clk); #1;
            cyc++;
            if (hammer) scramble_inputs();
        end
        start_i = 1'b0;
        check("done_seen", 32'(done_o), 32'd1);
        check("latency", 32'(cyc), 32'(lat));
        check("result", ALU_Result_o, exp);
        check("zero", 32'(Zero_o), 32'(exp == 32'h0));
        check("busy_at_done", 32'(busy_o), 32'd0);
        last_res = exp;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            check("idle_done", 32'(done_o), 32'd0);
            check("idle_hold", ALU_Result_o, last_res);
            check("idle_zero", 32'(Zero_o), 32'(last_res == 32'h0));
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          saw_done;

        reset = 1'b1;
        start_i = 1'b0;
        ALU_Operation_i = 4'd0;
        A_i = 32'h0;
        B_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", ALU_Result_o, 32'h0);
        check("rst_zero", 32'(Zero_o), 32'd1);
        reset = 1'b0;
        idle(1);

        // Directed cases
        run(4'd0, 32'd5, 32'd7, 1'b0);
        idle(1);
        run(4'd1, 32'd3, 32'd3, 1'b0);
        run(4'd1, 32'd0, 32'd1, 1'b0);
        run(4'd7, 32'd1, 32'd31, 1'b0);
        run(4'd6, 32'hF000_0000, 32'h24, 1'b1);
        run(4'd4, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
        run(4'd5, 32'h0, 32'hABCDE_FFF, 1'b0);
        run(4'd6, 32'hDEAD_BEEF, 32'h40, 1'b0);
        run(4'd12, 32'hFFFF_FFFF, 32'h1, 1'b0);
        idle(2);

        // Reset in the middle of a shift of 10
        start_i = 1'b1;
        ALU_Operation_i = 4'd7;
        A_i = 32'h0000_0F0F;
        B_i = 32'd10;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_result", ALU_Result_o, 32'h0);
        check("abort_zero", 32'(Zero_o), 32'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        last_res = 32'h0;
        run(4'd10, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);

        // start_i together with reset is dropped
        reset = 1'b1;
        start_i = 1'b1;
        ALU_Operation_i = 4'd0;
        A_i = 32'd5;
        B_i = 32'd7;
        @(posedge clk); #1;
        reset = 1'b0;
        start_i = 1'b0;
        check("rst_start_done", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        check("rst_start_done2", 32'(done_o), 32'd0);
        check("rst_start_result", ALU_Result_o, 32'h0);
        last_res = 32'h0;

        // Randomized sequence
        for (int t = 0; t < 150; t++) begin
            rop = 4'($urandom);
            if ($urandom_range(2, 0) == 0) rop = 4'(6 + $urandom_range(1, 0));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7, 0) == 0) rb = rb & 32'hFFFF_FFE0;
            if ($urandom_range(5, 0) == 0) ra = ra & 32'h0000_00FF;
            run(rop, ra, rb, 1'($urandom));
            idle(int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
